// File: rtl/am_handler_router.sv
// am_handler_router: takes one AXI-Stream of active messages, strips the
// one-beat AM header and passes the payload straight through to one of
// NUM_KERNELS handler streams. The handler is chosen by the header's
// destination minus address_offset. Packets whose destination is out of
// range are discarded. Header-only packets and discarded packets are
// counted, and both counters saturate.
module am_handler_router #(
    parameter int NUM_KERNELS   = 16,
    parameter int DATA_WIDTH    = 64,
    parameter int DEST_LSB      = 24,
    parameter int DEST_WIDTH    = 16,
    parameter int HANDLER_LSB   = 52,
    parameter int HANDLER_WIDTH = 4,
    localparam int KERNEL_WIDTH = (NUM_KERNELS == 1) ? 1 : $clog2(NUM_KERNELS)
) (
    input  logic                     clock,
    input  logic                     reset_n,
    input  logic [DATA_WIDTH-1:0]    s_axis_tdata,
    input  logic                     s_axis_tvalid,
    input  logic                     s_axis_tlast,
    output logic                     s_axis_tready,
    input  logic [DEST_WIDTH-1:0]    address_offset,
    output logic [DATA_WIDTH-1:0]    m_axis_tdata,
    output logic                     m_axis_tlast,
    output logic [NUM_KERNELS-1:0]   m_axis_tvalid,
    input  logic [NUM_KERNELS-1:0]   m_axis_tready,
    output logic [HANDLER_WIDTH-1:0] m_handler,
    output logic [KERNEL_WIDTH-1:0]  active_kernel,
    output logic                     busy,
    output logic [15:0]              drop_count,
    output logic [15:0]              hdr_only_count
);

    typedef enum logic [1:0] {
        ST_HEADER  = 2'd0,
        ST_PAYLOAD = 2'd1,
        ST_DROP    = 2'd2
    } state_t;

    // The range check is done 9 bits wider than the destination field, so
    // that NUM_KERNELS up to 256 is never truncated, even for a narrow field.
    localparam int CMP_W = DEST_WIDTH + 9;
    localparam logic [CMP_W-1:0] NK = CMP_W'(NUM_KERNELS);

    state_t                  state, state_next;
    logic [DEST_WIDTH-1:0]   rel;
    logic [CMP_W-1:0]        rel_ext;
    logic                    valid_dest;
    logic                    inc_drop, inc_hdr;
    logic                    hs;

    assign m_axis_tdata = s_axis_tdata;
    assign m_axis_tlast = s_axis_tlast;
    assign busy         = (state != ST_HEADER);
    assign hs           = s_axis_tvalid && s_axis_tready;

    // Decode the destination relative to the offset (wrapping subtraction).
    always_comb begin
        rel        = s_axis_tdata[DEST_LSB +: DEST_WIDTH] - address_offset;
        rel_ext    = {9'b0, rel};
        valid_dest = (rel_ext < NK);
    end

    // Stream handshake signals: the payload is passed through to the selected kernel, and the header and dropped beats are absorbed.
    always_comb begin
        m_axis_tvalid = '0;
        s_axis_tready = 1'b1;
        if (state == ST_PAYLOAD) begin
            m_axis_tvalid[active_kernel] = s_axis_tvalid;
            s_axis_tready                = m_axis_tready[active_kernel];
        end
    end

    // Next-state decode and counter increment requests.
    always_comb begin
        state_next = state;
        inc_drop   = 1'b0;
        inc_hdr    = 1'b0;
        case (state)
            ST_HEADER: begin
                if (s_axis_tvalid) begin
                    if (s_axis_tlast) begin
                        if (valid_dest) inc_hdr  = 1'b1;
                        else            inc_drop = 1'b1;
                    end else if (valid_dest) begin
                        state_next = ST_PAYLOAD;
                    end else begin
                        state_next = ST_DROP;
                        inc_drop   = 1'b1;
                    end
                end
            end
            ST_PAYLOAD: if (hs && s_axis_tlast) state_next = ST_HEADER;
            ST_DROP:    if (s_axis_tvalid && s_axis_tlast) state_next = ST_HEADER;
            default:    state_next = ST_HEADER;
        endcase
    end

    // State register.
    always_ff @(posedge clock) begin
        if (!reset_n) state <= ST_HEADER;
        else          state <= state_next;
    end

    // Latch the routing fields on a header handshake, and update the saturating counters.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            active_kernel  <= '0;
            m_handler      <= '0;
            drop_count     <= '0;
            hdr_only_count <= '0;
        end else begin
            if (state == ST_HEADER && s_axis_tvalid) begin
                active_kernel <= rel_ext[KERNEL_WIDTH-1:0];
                m_handler     <= s_axis_tdata[HANDLER_LSB +: HANDLER_WIDTH];
            end
            if (inc_drop && drop_count != '1)     drop_count     <= drop_count + 16'd1;
            if (inc_hdr && hdr_only_count != '1)  hdr_only_count <= hdr_only_count + 16'd1;
        end
    end

endmodule

// File: tb/tb_am_handler_router.sv
// Directed testbench for am_handler_router with the default parameters (16 kernels, 64-bit data).
module tb_am_handler_router;

    logic        clock = 1'b0;
    logic        reset_n;
    logic [63:0] s_axis_tdata;
    logic        s_axis_tvalid;
    logic        s_axis_tlast;
    logic        s_axis_tready;
    logic [15:0] address_offset;
    logic [63:0] m_axis_tdata;
    logic        m_axis_tlast;
    logic [15:0] m_axis_tvalid;
    logic [15:0] m_axis_tready;
    logic [3:0]  m_handler;
    logic [3:0]  active_kernel;
    logic        busy;
    logic [15:0] drop_count;
    logic [15:0] hdr_only_count;

    int checks   = 0;
    int failures = 0;

    always #5 clock = ~clock;

    am_handler_router #(.NUM_KERNELS(16), .DATA_WIDTH(64)) dut (
        .clock          (clock),
        .reset_n        (reset_n),
        .s_axis_tdata   (s_axis_tdata),
        .s_axis_tvalid  (s_axis_tvalid),
        .s_axis_tlast   (s_axis_tlast),
        .s_axis_tready  (s_axis_tready),
        .address_offset (address_offset),
        .m_axis_tdata   (m_axis_tdata),
        .m_axis_tlast   (m_axis_tlast),
        .m_axis_tvalid  (m_axis_tvalid),
        .m_axis_tready  (m_axis_tready),
        .m_handler      (m_handler),
        .active_kernel  (active_kernel),
        .busy           (busy),
        .drop_count     (drop_count),
        .hdr_only_count (hdr_only_count)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] hdr(input logic [15:0] dest, input logic [3:0] handler);
        return (64'(dest) << 24) | (64'(handler) << 52);
    endfunction

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    // Present one valid beat, check the combinational outputs mid-cycle, then clock it.
    task automatic xfer(input string tag, input logic [63:0] d, input logic l,
                        input logic [15:0] rdy, input logic [15:0] exp_mv, input logic exp_rdy);
        s_axis_tdata  = d;
        s_axis_tvalid = 1'b1;
        s_axis_tlast  = l;
        m_axis_tready = rdy;
        @(negedge clock);
        check({tag, "_mvalid"}, 64'(m_axis_tvalid), 64'(exp_mv));
        check({tag, "_sready"}, 64'(s_axis_tready), 64'(exp_rdy));
        if (exp_mv != 16'h0) begin
            check({tag, "_mdata"}, m_axis_tdata, d);
            check({tag, "_mlast"}, 64'(m_axis_tlast), 64'(l));
        end
        step();
    endtask

    initial begin
        logic [3:0]  rdy_pat [5];
        logic [63:0] dat;
        int          sent;

        reset_n        = 1'b0;
        s_axis_tdata   = '0;
        s_axis_tvalid  = 1'b0;
        s_axis_tlast   = 1'b0;
        m_axis_tready  = '0;
        address_offset = 16'h0100;
        step();
        step();
        check("rst_busy",   64'(busy), 64'd0);
        check("rst_mvalid", 64'(m_axis_tvalid), 64'd0);
        check("rst_kernel", 64'(active_kernel), 64'd0);
        check("rst_handler",64'(m_handler), 64'd0);
        check("rst_drop",   64'(drop_count), 64'd0);
        check("rst_hdr",    64'(hdr_only_count), 64'd0);
        reset_n = 1'b1;

        // Basic routing: dest 0x103 -> kernel 3, handler 5
        xfer("t1_hdr", hdr(16'h0103, 4'h5), 1'b0, 16'hFFFF, 16'h0, 1'b1);
        check("t1_busy",    64'(busy), 64'd1);
        check("t1_kernel",  64'(active_kernel), 64'd3);
        check("t1_handler", 64'(m_handler), 64'd5);
        for (int i = 0; i < 3; i++)
            xfer("t1_pay", 64'hA0 + 64'(i), (i == 2), 16'hFFFF, 16'h0008, 1'b1);
        check("t1_idle", 64'(busy), 64'd0);
        check("t1_drop", 64'(drop_count), 64'd0);
        check("t1_hdro", 64'(hdr_only_count), 64'd0);

        // Backpressure on kernel 3 only; all other readies held low
        xfer("t2_hdr", hdr(16'h0103, 4'h5), 1'b0, 16'h0000, 16'h0, 1'b1);
        rdy_pat = '{4'd1, 4'd0, 4'd0, 4'd1, 4'd1};
        sent = 0;
        for (int c = 0; c < 5; c++) begin
            dat = 64'hB0 + 64'(sent);
            xfer("t2_pay", dat, (sent == 2), {12'h000, rdy_pat[c][0], 3'b000}, 16'h0008, rdy_pat[c][0]);
            if (rdy_pat[c][0]) sent++;
        end
        check("t2_beats", 64'(sent), 64'd3);
        check("t2_idle",  64'(busy), 64'd0);

        // Out-of-range destination (rel=16) is dropped, whatever the readies
        xfer("t3_hdr", hdr(16'h0110, 4'h2), 1'b0, 16'h0000, 16'h0, 1'b1);
        check("t3_busy", 64'(busy), 64'd1);
        check("t3_drop", 64'(drop_count), 64'd1);
        for (int i = 0; i < 4; i++)
            xfer("t3_pay", 64'hC0 + 64'(i), (i == 3), 16'h0000, 16'h0, 1'b1);
        check("t3_idle", 64'(busy), 64'd0);
        xfer("t3_next_hdr", hdr(16'h0102, 4'h1), 1'b0, 16'hFFFF, 16'h0, 1'b1);
        xfer("t3_next_pay", 64'hD0, 1'b1, 16'hFFFF, 16'h0004, 1'b1);

        // tvalid low carrying a bad header: no state or counter change
        s_axis_tdata  = hdr(16'h0000, 4'h0);
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;
        step();
        step();
        check("tv_busy", 64'(busy), 64'd0);
        check("tv_drop", 64'(drop_count), 64'd1);

        // Wrapping destination: 0x00FF - 0x0100 = 0xFFFF
        xfer("t4_hdr", hdr(16'h00FF, 4'h3), 1'b0, 16'hFFFF, 16'h0, 1'b1);
        check("t4_busy", 64'(busy), 64'd1);
        check("t4_drop", 64'(drop_count), 64'd2);
        xfer("t4_pay", 64'hE0, 1'b1, 16'hFFFF, 16'h0, 1'b1);

        // Header-only packet, then a packet to kernel 0 with no bubble
        xfer("t5_hdronly", hdr(16'h0100, 4'h9), 1'b1, 16'hFFFF, 16'h0, 1'b1);
        check("t5_busy", 64'(busy), 64'd0);
        check("t5_hdro", 64'(hdr_only_count), 64'd1);
        check("t5_handler", 64'(m_handler), 64'd9);
        xfer("t5_hdr", hdr(16'h0100, 4'h7), 1'b0, 16'hFFFF, 16'h0, 1'b1);
        check("t5_busy2", 64'(busy), 64'd1);
        xfer("t5_pay", 64'hF0, 1'b1, 16'hFFFF, 16'h0001, 1'b1);

        // Reset in the middle of a packet to kernel 10
        xfer("t6_hdr", hdr(16'h010A, 4'hC), 1'b0, 16'hFFFF, 16'h0, 1'b1);
        xfer("t6_pay0", 64'h11, 1'b0, 16'hFFFF, 16'h0400, 1'b1);
        xfer("t6_pay1", 64'h12, 1'b0, 16'hFFFF, 16'h0400, 1'b1);
        reset_n = 1'b0;
        step();
        check("t6_busy",   64'(busy), 64'd0);
        check("t6_mvalid", 64'(m_axis_tvalid), 64'd0);
        check("t6_kernel", 64'(active_kernel), 64'd0);
        check("t6_drop",   64'(drop_count), 64'd0);
        reset_n = 1'b1;
        xfer("t6_newhdr", hdr(16'h0105, 4'h6), 1'b0, 16'hFFFF, 16'h0, 1'b1);
        check("t6_kernel5", 64'(active_kernel), 64'd5);
        check("t6_handler", 64'(m_handler), 64'd6);
        xfer("t6_pay", 64'h13, 1'b1, 16'hFFFF, 16'h0020, 1'b1);

        // Saturation: a stream of back-to-back bad header-only packets
        s_axis_tdata  = hdr(16'h0000, 4'h0);
        s_axis_tvalid = 1'b1;
        s_axis_tlast  = 1'b1;
        repeat (65534) step();
        check("sat_below", 64'(drop_count), 64'hFFFE);
        step();
        check("sat_reach", 64'(drop_count), 64'hFFFF);
        repeat (3) step();
        check("sat_hold",  64'(drop_count), 64'hFFFF);
        check("sat_hdro",  64'(hdr_only_count), 64'd0);
        s_axis_tvalid = 1'b0;
        step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
